// File: rtl/instr_seq_pkg.sv
// Shared definitions for the instruction sequencer.
// Contents: the sequencer state enum, IR field positions, link-register index,
// PC reset/step defaults, write-class opcode constants and the helpers that
// classify an opcode field IR[27:24].
package instr_seq_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_e;

    // IR field LSB positions (each field is 4 bits wide)
    localparam int unsigned IR_OPC_LSB = 24;
    localparam int unsigned IR_RN_LSB  = 16;
    localparam int unsigned IR_RD_LSB  = 12;
    localparam int unsigned IR_RS_LSB  = 8;
    localparam int unsigned IR_RM_LSB  = 0;

    localparam logic [3:0]  LR_IDX       = 4'd14;
    localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEF  = 32'd4;

    // Write-class opcode constants
    localparam logic [1:0] OPC_DP     = 2'b00;   // IR[27:26]
    localparam logic [2:0] OPC_BRANCH = 3'b101;  // IR[27:25]

    // Branch-with-link: IR[27:25]==101 and IR[24] set
    function automatic logic is_link(input logic [3:0] opc);
        return (opc[3:1] == OPC_BRANCH) && opc[0];
    endfunction

    // Any instruction that writes the register file in WB
    function automatic logic is_write(input logic [3:0] opc);
        return (opc[3:2] == OPC_DP) || is_link(opc);
    endfunction

endpackage

// File: rtl/instr_seq_ctrl_if.sv
// Bus bundle between the sequencer and its neighbours.
// imem_*       : instruction fetch req/ack handshake (sequencer drives req/addr)
// alu_done,
// branch_*     : execute datapath completion and branch resolution
// master modport = sequencer side, slave modport = memory/datapath side.
interface instr_seq_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        alu_done;
    logic        branch_taken;
    logic [31:0] branch_target;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata, alu_done, branch_taken, branch_target
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata, alu_done, branch_taken, branch_target
    );
endinterface

// File: rtl/instr_seq_ctrl_pc_next_unit.sv
// Program counter register with incrementer, branch mux and target alignment.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   latch_en     : capture taken/target (end of EXEC)
//   taken_in     : branch taken flag to capture
//   target_in    : branch target to capture (low two bits dropped)
//   commit       : load the next PC (WB cycle)
//   pc_o         : current PC
//   pc_next_o    : PC that will be loaded at the next commit
module pc_next_unit
    import instr_seq_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        latch_en,
    input  logic        taken_in,
    input  logic [31:0] target_in,
    input  logic        commit,
    output logic [31:0] pc_o,
    output logic [31:0] pc_next_o
);

    logic [31:0] pc_q, pc_d;
    logic        br_taken_q, br_taken_d;
    logic [31:0] br_target_q, br_target_d;
    logic [31:0] pc_inc_s;
    logic [31:0] pc_sel_s;
    logic        unused_tgt_s;

    // Target is word aligned, so its byte-offset bits are never used
    assign unused_tgt_s = ^target_in[1:0];

    // Next-PC selection and branch capture
    always_comb begin
        pc_inc_s    = pc_q + PC_STEP;  // wraps modulo 2^32
        pc_sel_s    = br_taken_q ? br_target_q : pc_inc_s;
        br_taken_d  = br_taken_q;
        br_target_d = br_target_q;
        pc_d        = pc_q;
        if (latch_en) begin
            br_taken_d  = taken_in;
            br_target_d = {target_in[31:2], 2'b00};
        end else if (commit) begin
            // Branch decision is consumed by this commit
            br_taken_d  = 1'b0;
            pc_d        = pc_sel_s;
        end else begin
            pc_d        = pc_q;
        end
    end

    // PC and latched branch registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= PC_RESET;
            br_taken_q  <= 1'b0;
            br_target_q <= 32'h0000_0000;
        end else begin
            pc_q        <= pc_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
        end
    end

    assign pc_o      = pc_q;
    assign pc_next_o = pc_sel_s;

endmodule

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> WB.
// Owns the PC, fetches over a req/ack handshake, registers the register-file
// address fields, waits for the datapath, then pulses the write enable and
// commits the next PC.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   bus (master)       : imem_req/addr/ack/rdata, alu_done, branch_taken/target
//   ARn, ARd, ARs, ARm : register addresses (ARd forced to LR for branch-link)
//   wen_ARd            : one-cycle write enable in WB
//   wb_sel             : 0 = ALU result, 1 = link value
//   PC_out, PC_next    : current PC, PC committed at the end of WB
//   state_o            : current state (debug)
module instr_seq_ctrl
    import instr_seq_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    instr_seq_ctrl_if.master        bus,
    output logic [3:0]              ARn,
    output logic [3:0]              ARd,
    output logic [3:0]              ARs,
    output logic [3:0]              ARm,
    output logic                    wen_ARd,
    output logic                    wb_sel,
    output logic [31:0]             PC_out,
    output logic [31:0]             PC_next,
    output logic [1:0]              state_o
);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [3:0]  arn_q, arn_d, ard_q, ard_d, ars_q, ars_d, arm_q, arm_d;
    logic        wen_q, wen_d;
    logic        wb_sel_q, wb_sel_d;
    logic        req_q, req_d;
    logic        latch_en_s;
    logic        commit_s;
    logic [3:0]  ir_opc_s;
    logic [3:0]  rd_opc_s;
    logic        unused_ir_s;

    assign ir_opc_s    = ir_q[IR_OPC_LSB +: 4];
    assign rd_opc_s    = bus.imem_rdata[IR_OPC_LSB +: 4];
    // Only the opcode field of IR is needed after the fetch edge
    assign unused_ir_s = ^{ir_q[31:28], ir_q[23:0]};

    // Next-state, decode and registered-output computation
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        arn_d      = arn_q;
        ard_d      = ard_q;
        ars_d      = ars_q;
        arm_d      = arm_q;
        wen_d      = 1'b0;
        wb_sel_d   = 1'b0;
        req_d      = 1'b0;
        latch_en_s = 1'b0;
        commit_s   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    // Fields are captured straight from the bus so they are
                    // already valid during DECODE.
                    ir_d    = bus.imem_rdata;
                    arn_d   = bus.imem_rdata[IR_RN_LSB +: 4];
                    ard_d   = is_link(rd_opc_s) ? LR_IDX
                                                : bus.imem_rdata[IR_RD_LSB +: 4];
                    ars_d   = bus.imem_rdata[IR_RS_LSB +: 4];
                    arm_d   = bus.imem_rdata[IR_RM_LSB +: 4];
                    state_d = ST_DECODE;
                    req_d   = 1'b0;
                end else begin
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (bus.alu_done) begin
                    latch_en_s = 1'b1;
                    // WB strobes are set on this edge so they are flop outputs
                    wen_d      = is_write(ir_opc_s);
                    wb_sel_d   = is_link(ir_opc_s);
                    state_d    = ST_WB;
                end else begin
                    state_d    = ST_EXEC;
                end
            end
            ST_WB: begin
                commit_s = 1'b1;
                state_d  = ST_FETCH;
                req_d    = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
            end
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            ir_q     <= 32'h0000_0000;
            arn_q    <= 4'd0;
            ard_q    <= 4'd0;
            ars_q    <= 4'd0;
            arm_q    <= 4'd0;
            wen_q    <= 1'b0;
            wb_sel_q <= 1'b0;
            req_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            arn_q    <= arn_d;
            ard_q    <= ard_d;
            ars_q    <= ars_d;
            arm_q    <= arm_d;
            wen_q    <= wen_d;
            wb_sel_q <= wb_sel_d;
            req_q    <= req_d;
        end
    end

    pc_next_unit #(
        .PC_RESET (PC_RESET),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .latch_en  (latch_en_s),
        .taken_in  (bus.branch_taken),
        .target_in (bus.branch_target),
        .commit    (commit_s),
        .pc_o      (PC_out),
        .pc_next_o (PC_next)
    );

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = PC_out;
    assign ARn           = arn_q;
    assign ARd           = ard_q;
    assign ARs           = ars_q;
    assign ARm           = arm_q;
    assign wen_ARd       = wen_q;
    assign wb_sel        = wb_sel_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Self-checking bench for instr_seq_ctrl: a directed vector table, randomized
// instructions checked against a transaction-level model, and hand-written
// reset-abort sequences. Inputs are driven and outputs sampled on negedge.
module tb_instr_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  arn, ard, ars, arm;
    logic        wen, wbsel;
    logic [31:0] pc_out, pc_next;
    logic [1:0]  st;

    instr_seq_ctrl_if bus ();

    instr_seq_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .ARn     (arn),
        .ARd     (ard),
        .ARs     (ars),
        .ARm     (arm),
        .wen_ARd (wen),
        .wb_sel  (wbsel),
        .PC_out  (pc_out),
        .PC_next (pc_next),
        .state_o (st)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] model_pc;

    typedef struct {
        logic [31:0] instr;
        int          fw;      // fetch wait cycles before ack
        int          ew;      // exec wait cycles before alu_done
        bit          taken;
        logic [31:0] tgt;
        logic [3:0]  exp_ard;
        bit          exp_wen;
        bit          exp_wbsel;
        logic [31:0] exp_pc;  // PC after this instruction
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one instruction with the given wait counts and check every cycle.
    task automatic run_instr(input logic [31:0] instr, input int fw, input int ew,
                             input bit taken, input logic [31:0] tgt,
                             input logic [3:0] exp_ard, input bit exp_wen,
                             input bit exp_wbsel, input logic [31:0] exp_pc);
        int total;
        total = fw + ew + 4;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            if (c <= fw) begin
                chk("fetch_state", 32'(st), 32'd0);
                chk("fetch_req", 32'(bus.imem_req), 32'd1);
                chk("fetch_addr", bus.imem_addr, model_pc);
                chk("fetch_wen", 32'(wen), 32'd0);
                bus.imem_ack     = (c == fw);
                bus.imem_rdata   = (c == fw) ? instr : $urandom;
                bus.alu_done     = 1'($urandom_range(0, 1));
                bus.branch_taken = 1'($urandom_range(0, 1));
                bus.branch_target = $urandom;
            end else if (c == fw + 1) begin
                chk("dec_state", 32'(st), 32'd1);
                chk("dec_req", 32'(bus.imem_req), 32'd0);
                chk("dec_arn", 32'(arn), 32'(instr[19:16]));
                chk("dec_ard", 32'(ard), 32'(exp_ard));
                chk("dec_wen", 32'(wen), 32'd0);
                bus.imem_ack   = 1'($urandom_range(0, 1));
                bus.imem_rdata = $urandom;
                bus.alu_done   = 1'($urandom_range(0, 1));
            end else if (c < total - 1) begin
                chk("exec_state", 32'(st), 32'd2);
                chk("exec_ars", 32'(ars), 32'(instr[11:8]));
                chk("exec_arm", 32'(arm), 32'(instr[3:0]));
                chk("exec_wen", 32'(wen), 32'd0);
                chk("exec_wbsel", 32'(wbsel), 32'd0);
                chk("exec_pc", pc_out, model_pc);
                bus.imem_ack = 1'($urandom_range(0, 1));
                bus.alu_done = (c == total - 2);
                if (c == total - 2) begin
                    bus.branch_taken  = taken;
                    bus.branch_target = tgt;
                end else begin
                    bus.branch_taken  = 1'($urandom_range(0, 1));
                    bus.branch_target = $urandom;
                end
            end else begin
                chk("wb_state", 32'(st), 32'd3);
                chk("wb_wen", 32'(wen), 32'(exp_wen));
                chk("wb_sel", 32'(wbsel), 32'(exp_wbsel));
                chk("wb_ard", 32'(ard), 32'(exp_ard));
                chk("wb_arn", 32'(arn), 32'(instr[19:16]));
                chk("wb_pc_next", pc_next, exp_pc);
                chk("wb_pc_out", pc_out, model_pc);
                chk("wb_req", 32'(bus.imem_req), 32'd0);
                bus.imem_ack = 1'($urandom_range(0, 1));
                bus.alu_done = 1'($urandom_range(0, 1));
            end
        end
        model_pc = exp_pc;
    endtask

    initial begin
        logic [31:0] ins, tgt;
        logic [3:0]  rd;
        bit          bl, wr, tk;

        tbl[0] = '{32'hE081_2003, 0, 0, 1'b0, 32'h0000_0000, 4'd2,  1'b1, 1'b0, 32'h0000_0004};
        tbl[1] = '{32'hE081_2003, 3, 2, 1'b0, 32'h0000_0000, 4'd2,  1'b1, 1'b0, 32'h0000_0008};
        tbl[2] = '{32'hEB00_0010, 0, 0, 1'b1, 32'h0000_0103, 4'd14, 1'b1, 1'b1, 32'h0000_0100};
        tbl[3] = '{32'h0A00_0000, 1, 1, 1'b1, 32'hFFFF_FFFF, 4'd0,  1'b0, 1'b0, 32'hFFFF_FFFC};
        tbl[4] = '{32'hE081_2003, 0, 1, 1'b0, 32'h0000_0000, 4'd2,  1'b1, 1'b0, 32'h0000_0000};
        tbl[5] = '{32'h0400_5000, 2, 0, 1'b0, 32'h0000_0000, 4'd5,  1'b0, 1'b0, 32'h0000_0004};
        tbl[6] = '{32'h0C00_A000, 0, 0, 1'b0, 32'h0000_0000, 4'd10, 1'b0, 1'b0, 32'h0000_0008};
        tbl[7] = '{32'hEB00_3000, 1, 0, 1'b0, 32'h0000_0040, 4'd14, 1'b1, 1'b1, 32'h0000_000C};

        rst_n = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0000_0000;
        bus.alu_done = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = 32'h0000_0000;

        // Reset held two cycles
        repeat (2) @(negedge clk);
        chk("rst_pc", pc_out, 32'h0000_0000);
        chk("rst_state", 32'(st), 32'd0);
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_wbsel", 32'(wbsel), 32'd0);
        chk("rst_ard", 32'(ard), 32'd0);
        rst_n = 1'b1;
        model_pc = 32'h0000_0000;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            run_instr(tbl[i].instr, tbl[i].fw, tbl[i].ew, tbl[i].taken, tbl[i].tgt,
                      tbl[i].exp_ard, tbl[i].exp_wen, tbl[i].exp_wbsel, tbl[i].exp_pc);
        end

        // Randomized instructions against the transaction-level model
        for (int i = 0; i < 60; i++) begin
            ins = $urandom;
            case ($urandom_range(0, 3))
                0: ins[27:26] = 2'b00;
                1: ins[27:24] = 4'b1011;
                2: ins[27:24] = 4'b1010;
                default: ins[27:26] = 2'b11;
            endcase
            tk  = 1'($urandom_range(0, 1));
            tgt = $urandom;
            bl  = (ins[27:25] == 3'b101) && ins[24];
            wr  = (ins[27:26] == 2'b00) || bl;
            rd  = bl ? 4'd14 : ins[15:12];
            run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), tk, tgt, rd, wr, bl,
                      tk ? (tgt & 32'hFFFF_FFFC) : model_pc + 32'd4);
        end

        // Reset during EXEC while alu_done is pending
        @(negedge clk);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hE081_2003;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        @(negedge clk);
        chk("abort_in_exec", 32'(st), 32'd2);
        bus.alu_done = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h0000_0200;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_state", 32'(st), 32'd0);
        chk("abort_wen", 32'(wen), 32'd0);
        chk("abort_pc", pc_out, 32'h0000_0000);
        bus.alu_done = 1'b0;
        bus.branch_taken = 1'b0;
        @(negedge clk);
        chk("abort_wen2", 32'(wen), 32'd0);

        // Reset in FETCH with an ack the same cycle: fetch is discarded
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hE0F7_6543;
        @(negedge clk);
        chk("ackrst_state", 32'(st), 32'd0);
        chk("ackrst_arn", 32'(arn), 32'd0);
        chk("ackrst_ard", 32'(ard), 32'd0);
        bus.imem_ack = 1'b0;
        rst_n = 1'b1;
        model_pc = 32'h0000_0000;
        run_instr(tbl[0].instr, 0, 0, 1'b0, 32'h0000_0000, 4'd2, 1'b1, 1'b0, 32'h0000_0004);
        @(negedge clk);
        chk("final_pc", pc_out, 32'h0000_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
